// File: rtl/booth_mul_pkg.sv
// Shared types for the Booth multiplier arbiter: FSM states, Booth step decode, default sizes.
package booth_mul_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_NREQ  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      NOP = 2'd0,
      ADD = 2'd1,
      SUB = 2'd2
   } booth_op_t;

   // {Q[0], Q-1}: 10 -> subtract M, 01 -> add M, 00/11 -> no change.
   function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
      case ({q0, q_m1})
         2'b10:   return SUB;
         2'b01:   return ADD;
         default: return NOP;
      endcase
   endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/sub of M into A, then arithmetic shift of {A,Q,Q-1}.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module booth_step
   import booth_mul_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] q,
   input  logic             q_m1,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH:0]   acc_nxt,
   output logic [WIDTH-1:0] q_nxt,
   output logic             q_m1_nxt
);

   logic [WIDTH:0] m_ext;
   logic [WIDTH:0] sum;

   // A carries one guard bit so that M = -2^(WIDTH-1) cannot overflow the add.
   assign m_ext = {m[WIDTH-1], m};

   always_comb begin
      sum = acc;
      case (booth_decode(q[0], q_m1))
         ADD:     sum = acc + m_ext;
         SUB:     sum = acc - m_ext;
         default: sum = acc;
      endcase
   end

   assign acc_nxt  = {sum[WIDTH], sum[WIDTH:1]};
   assign q_nxt    = {sum[0], q[WIDTH-1:1]};
   assign q_m1_nxt = q[0];

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin shares one iterative Booth multiplier among NREQ requesters; BOOTH_MUL_ZERO_BYPASS_EN skips RUN for zero operands.
// Latency: rsp_valid WIDTH+1 cycles after the accept cycle (1 cycle with zero bypass).
// Backpressure: rsp_ready low holds DONE with a stable product; no grants outside IDLE.
module booth_mul_arbiter
   import booth_mul_pkg::*;
#(
   parameter  int NREQ  = DEF_NREQ,
   parameter  int WIDTH = DEF_WIDTH,
   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [2*WIDTH-1:0]    rsp_product,
   output logic                  busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef struct packed {
      logic [WIDTH:0]   acc;
      logic [WIDTH-1:0] q;
      logic             q_m1;
   } booth_reg_t;

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] m;
   booth_reg_t       op;
   booth_reg_t       op_nxt;

   logic             grant_any;
   logic [IDW-1:0]   win;
   logic [IDW:0]     cand;
   logic [IDW-1:0]   nxt_ptr;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;

   // First valid requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      grant_any = 1'b0;
      win       = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
         if (!grant_any && req_valid[cand[IDW-1:0]]) begin
            grant_any = 1'b1;
            win       = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      win_a = '0;
      win_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IDW'(i)) begin
            win_a = req_a[i*WIDTH +: WIDTH];
            win_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   assign nxt_ptr = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

   always_comb begin
      req_ready = '0;
      if (state == IDLE && grant_any && !rst) req_ready[win] = 1'b1;
   end

   booth_step #(.WIDTH(WIDTH)) u_step (
      .acc      (op.acc),
      .q        (op.q),
      .q_m1     (op.q_m1),
      .m        (m),
      .acc_nxt  (op_nxt.acc),
      .q_nxt    (op_nxt.q),
      .q_m1_nxt (op_nxt.q_m1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rr_ptr <= '0;
         count  <= '0;
         m      <= '0;
         op     <= '0;
         rsp_id <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  m       <= win_a;
                  op.acc  <= '0;
                  op.q    <= win_b;
                  op.q_m1 <= 1'b0;
                  count   <= CW'(WIDTH);
                  rr_ptr  <= nxt_ptr;
                  rsp_id  <= win;
                  state   <= RUN;
`ifdef BOOTH_MUL_ZERO_BYPASS_EN
                  if (win_a == '0 || win_b == '0) begin
                     op.q  <= '0;
                     count <= '0;
                     state <= DONE;
                  end
`endif
               end
            end
            RUN: begin
               op    <= op_nxt;
               count <= count - 1'b1;
               if (count == CW'(1)) state <= DONE;
            end
            DONE: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rsp_valid   = (state == DONE);
   assign busy        = (state != IDLE);
   assign rsp_product = {op.acc[WIDTH-1:0], op.q};

endmodule
